// File: rtl/uart_host_pkg.sv
// Shared types and constants for the CoreUART host-side sequencer.
package uart_host_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam logic        STB_ACT  = 1'b0;
  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IDX_W    = $clog2(MAX_NREQ);

  typedef enum logic [2:0] {
    StIdle,
    StWrStb,
    StRdStb,
    StRdWait,
    StRdCap,
    StGuardWait
  } state_e;

  typedef struct packed {
    logic              perr;
    logic              ferr;
    logic [BYTE_W-1:0] data;
  } rx_ent_t;

endpackage

// File: rtl/uart_rr_arb.sv
// Round-robin grant over NREQ requesters: first valid index at or after the pointer.
module uart_rr_arb
  import uart_host_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]  req_i,
  input  logic             update_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  output logic             any_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0]    ptr_q;
  logic [MAX_NREQ-1:0] req_pad;
  logic [IDX_W:0]      cand;

  always_comb begin
    req_pad           = '0;
    req_pad[NREQ-1:0] = req_i;
  end

  // Walk offsets from the highest down so the smallest offset from the pointer wins.
  always_comb begin
    any_o       = 1'b0;
    grant_idx_o = '0;
    cand        = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NREQ)) begin
        cand = cand - (IDX_W + 1)'(NREQ);
      end
      if (req_pad[cand[IDX_W-1:0]]) begin
        any_o       = 1'b1;
        grant_idx_o = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (update_i) begin
      ptr_q <= (upd_idx_i == IDX_W'(NREQ - 1)) ? '0 : upd_idx_i + 1'b1;
    end
  end

endmodule

// File: rtl/uart_host_ctrl.sv
// Host sequencer for the CoreUART wrapper: RR-arbitrated TX writes, prioritised RX reads.
// Define UART_HOST_CTRL_RXBUF_EN to replace the single RX slot with a 2-entry FIFO.
module uart_host_ctrl
  import uart_host_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned GUARD  = 2,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rx_valid,
  output logic [BYTE_W-1:0]      rx_data,
  output logic                   rx_perr,
  output logic                   rx_ferr,
  input  logic                   rx_ready,
  output logic                   ovf_sticky,
  output logic [IDX_W-1:0]       last_src,
  output logic                   uart_csn,
  output logic                   uart_wen,
  output logic                   uart_oen,
  output logic [BYTE_W-1:0]      uart_data_in,
  input  logic [BYTE_W-1:0]      uart_data_out,
  input  logic                   uart_txrdy,
  input  logic                   uart_rxrdy,
  input  logic                   uart_parity_err,
  input  logic                   uart_framing_err,
  input  logic                   uart_overflow
);

  state_e              state_q;
  logic [2:0]          cnt_q;
  logic [IDX_W-1:0]    grant_q;
  logic [IDX_W-1:0]    last_src_q;
  logic                csn_q, wen_q, oen_q, ovf_q;
  logic [BYTE_W-1:0]   data_in_q;
  logic [NREQ-1:0]     req_ready_q;

  logic                arb_any;
  logic [IDX_W-1:0]    arb_idx;
  logic [MAX_NREQ-1:0] grant_oh;
  logic [BYTE_W-1:0]   grant_byte;

  logic                rx_push, rx_pop, rx_avail, rx_free;
  rx_ent_t             rx_head, cap_ent;

  uart_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .req_i       (req_valid),
    .update_i    (state_q == StWrStb),
    .upd_idx_i   (grant_q),
    .any_o       (arb_any),
    .grant_idx_o (arb_idx)
  );

  assign grant_oh = MAX_NREQ'(1) << arb_idx;

  always_comb begin
    grant_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        grant_byte = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Strobes for the next cycle are decided together with the transition into the strobe state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      grant_q     <= '0;
      last_src_q  <= '0;
      csn_q       <= ~STB_ACT;
      wen_q       <= ~STB_ACT;
      oen_q       <= ~STB_ACT;
      data_in_q   <= '0;
      req_ready_q <= '0;
    end else begin
      csn_q       <= ~STB_ACT;
      wen_q       <= ~STB_ACT;
      oen_q       <= ~STB_ACT;
      req_ready_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (uart_rxrdy && rx_free) begin
            state_q <= StRdStb;
            csn_q   <= STB_ACT;
            oen_q   <= STB_ACT;
          end else if (uart_txrdy && arb_any) begin
            state_q     <= StWrStb;
            csn_q       <= STB_ACT;
            wen_q       <= STB_ACT;
            grant_q     <= arb_idx;
            data_in_q   <= grant_byte;
            req_ready_q <= grant_oh[NREQ-1:0];
          end
        end
        StWrStb: begin
          last_src_q <= grant_q;
          cnt_q      <= '0;
          state_q    <= StGuardWait;
        end
        StRdStb: begin
          cnt_q   <= '0;
          state_q <= (RD_LAT == 1) ? StRdCap : StRdWait;
        end
        StRdWait: begin
          if (cnt_q == 3'(RD_LAT - 2)) begin
            state_q <= StRdCap;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StRdCap: begin
          cnt_q   <= '0;
          state_q <= StGuardWait;
        end
        StGuardWait: begin
          if (cnt_q == 3'(GUARD - 1)) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | uart_overflow;
    end
  end

  assign cap_ent = '{perr: uart_parity_err, ferr: uart_framing_err, data: uart_data_out};
  assign rx_push = (state_q == StRdCap);
  assign rx_pop  = rx_avail & rx_ready;

`ifdef UART_HOST_CTRL_RXBUF_EN
  rx_ent_t    fifo_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] fifo_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= '0;
    end else begin
      if (rx_push) begin
        fifo_q[wr_ptr_q] <= cap_ent;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (rx_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, rx_push} - {1'b0, rx_pop};
    end
  end

  assign rx_avail = (fifo_cnt_q != 2'd0);
  assign rx_head  = fifo_q[rd_ptr_q];
  assign rx_free  = (fifo_cnt_q != 2'd2) | rx_pop;
`else
  rx_ent_t slot_q;
  logic    slot_vld_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
    end else if (rx_push) begin
      slot_q     <= cap_ent;
      slot_vld_q <= 1'b1;
    end else if (rx_pop) begin
      slot_vld_q <= 1'b0;
    end
  end

  assign rx_avail = slot_vld_q;
  assign rx_head  = slot_q;
  assign rx_free  = ~slot_vld_q | rx_pop;
`endif

  assign req_ready    = req_ready_q;
  assign rx_valid     = rx_avail;
  assign rx_data      = rx_head.data;
  assign rx_perr      = rx_head.perr;
  assign rx_ferr      = rx_head.ferr;
  assign ovf_sticky   = ovf_q;
  assign last_src     = last_src_q;
  assign uart_csn     = csn_q;
  assign uart_wen     = wen_q;
  assign uart_oen     = oen_q;
  assign uart_data_in = data_in_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Self-checking bench for uart_host_ctrl: directed scenarios plus randomized traffic vs a queue model.
module tb_uart_host_ctrl;

  localparam int NREQ   = 4;
  localparam int GUARD  = 2;
  localparam int RD_LAT = 1;
`ifdef UART_HOST_CTRL_RXBUF_EN
  localparam int RXCAP = 2;
`else
  localparam int RXCAP = 1;
`endif

  logic              CLK = 1'b0;
  logic              RESET;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_perr, rx_ferr, rx_ready, ovf_sticky;
  logic [2:0]        last_src;
  logic              uart_csn, uart_wen, uart_oen;
  logic [7:0]        uart_data_in, uart_data_out;
  logic              uart_txrdy, uart_rxrdy, uart_parity_err, uart_framing_err, uart_overflow;

  always #5 CLK = ~CLK;

  uart_host_ctrl #(
    .NREQ   (NREQ),
    .GUARD  (GUARD),
    .RD_LAT (RD_LAT)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .rx_perr          (rx_perr),
    .rx_ferr          (rx_ferr),
    .rx_ready         (rx_ready),
    .ovf_sticky       (ovf_sticky),
    .last_src         (last_src),
    .uart_csn         (uart_csn),
    .uart_wen         (uart_wen),
    .uart_oen         (uart_oen),
    .uart_data_in     (uart_data_in),
    .uart_data_out    (uart_data_out),
    .uart_txrdy       (uart_txrdy),
    .uart_rxrdy       (uart_rxrdy),
    .uart_parity_err  (uart_parity_err),
    .uart_framing_err (uart_framing_err),
    .uart_overflow    (uart_overflow)
  );

  int n_cmp, n_bad, cyc;

  // Requester byte queues (circular), UART receive queue, expected RX stream.
  logic [7:0] rq_buf [NREQ][64];
  int         rq_head [NREQ];
  int         rq_cnt  [NREQ];
  logic [9:0] src_q [$];
  logic [9:0] rx_exp [$];
  int         rd_cnt, rr_ptr, exp_last, last_stb, stb_gap;
  logic       exp_ovf;
  int         ev_kind [$];
  int         ev_idx [$];
  int         ev_cyc [$];
  int         ev_dat [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int count_kind(input int kind);
    int n = 0;
    foreach (ev_kind[j]) if (ev_kind[j] == kind) n++;
    return n;
  endfunction

  function automatic int pending();
    int n = src_q.size() + rx_exp.size() + ((rd_cnt > 0) ? 1 : 0);
    for (int i = 0; i < NREQ; i++) n += rq_cnt[i];
    return n;
  endfunction

  task automatic push_req(input int i, input logic [7:0] b);
    rq_buf[i][(rq_head[i] + rq_cnt[i]) % 64] = b;
    rq_cnt[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = (rq_cnt[i] > 0);
      req_data[8*i +: 8] = (rq_cnt[i] > 0) ? rq_buf[i][rq_head[i]] : 8'h00;
    end
    uart_rxrdy = (src_q.size() > 0);
    {uart_parity_err, uart_framing_err, uart_data_out} = (src_q.size() > 0) ? src_q[0] : 10'h0;
  endtask

  task automatic note_strobe(input int kind, input int idx, input int dat, input int gap);
    if (last_stb >= 0) check("strobe_spacing", 32'((cyc - last_stb) >= stb_gap), 1);
    last_stb = cyc;
    stb_gap  = gap;
    ev_kind.push_back(kind);
    ev_idx.push_back(idx);
    ev_cyc.push_back(cyc);
    ev_dat.push_back(dat);
  endtask

  // One clock: handshake before the edge, then model update and output checks after it.
  task automatic step();
    logic rst_in, ovf_in;
    int   g;
    drive();
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      check("rx_pop_expected", 32'(rx_exp.size() > 0), 1);
      if (rx_exp.size() > 0) begin
        check("rx_entry", {rx_perr, rx_ferr, rx_data}, rx_exp[0]);
        void'(rx_exp.pop_front());
      end
    end
    rst_in = RESET;
    ovf_in = uart_overflow;
    @(posedge CLK);
    #1;
    cyc++;
    if (rst_in) begin
      exp_ovf  = 1'b0;
      exp_last = 0;
      rr_ptr   = 0;
      last_stb = -1;
      rx_exp.delete();
      if (rd_cnt > 0 && src_q.size() > 0) void'(src_q.pop_front());
      rd_cnt = 0;
    end else begin
      exp_ovf = exp_ovf | ovf_in;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0 && src_q.size() > 0) rx_exp.push_back(src_q.pop_front());
      end
    end
    check("ovf_sticky", ovf_sticky, exp_ovf);
    check("last_src", last_src, exp_last);
    check("rx_valid", rx_valid, 32'(rx_exp.size() > 0));
    if (uart_csn === 1'b0 && uart_wen === 1'b0) begin
      g = -1;
      for (int k = NREQ - 1; k >= 0; k--) if (req_valid[(rr_ptr + k) % NREQ]) g = (rr_ptr + k) % NREQ;
      check("wr_has_request", 32'(g >= 0), 1);
      check("wr_txrdy", uart_txrdy, 1);
      check("wr_oen_high", uart_oen, 1);
      if (g >= 0) begin
        check("req_ready_grant", req_ready, 32'(1) << g);
        check("wr_data", uart_data_in, rq_buf[g][rq_head[g]]);
        note_strobe(0, g, int'(uart_data_in), GUARD + 2);
        rq_head[g] = (rq_head[g] + 1) % 64;
        rq_cnt[g]--;
        rr_ptr   = (g + 1) % NREQ;
        exp_last = g;
      end
    end else begin
      check("req_ready_idle", req_ready, 0);
      if (uart_csn === 1'b0 && uart_oen === 1'b0) begin
        check("rd_wen_high", uart_wen, 1);
        check("rd_room", 32'(rx_exp.size() < RXCAP), 1);
        check("rd_rxrdy", uart_rxrdy, 1);
        note_strobe(1, 0, 0, RD_LAT + GUARD + 2);
        rd_cnt = RD_LAT + 1;
      end else begin
        check("strobes_idle", {uart_csn, uart_wen, uart_oen}, 3'b111);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_all();
    for (int i = 0; i < NREQ; i++) begin
      rq_cnt[i]  = 0;
      rq_head[i] = 0;
    end
    src_q.delete();
    uart_txrdy    = 1'b0;
    rx_ready      = 1'b0;
    uart_overflow = 1'b0;
    RESET = 1'b1;
    run(2);
    RESET = 1'b0;
    ev_kind.delete();
    ev_idx.delete();
    ev_cyc.delete();
    ev_dat.delete();
  endtask

  initial begin
    int fair [5];
    int seen, budget, ri;
    n_cmp = 0; n_bad = 0; cyc = 0;
    rd_cnt = 0; rr_ptr = 0; exp_last = 0; exp_ovf = 1'b0; last_stb = -1; stb_gap = 0;
    for (int i = 0; i < NREQ; i++) begin
      rq_head[i] = 0;
      rq_cnt[i]  = 0;
    end
    req_valid = '0; req_data = '0; rx_ready = 1'b0; uart_txrdy = 1'b0; uart_overflow = 1'b0;
    uart_rxrdy = 1'b0; uart_data_out = '0; uart_parity_err = 1'b0; uart_framing_err = 1'b0;

    // Reset values
    RESET = 1'b1;
    run(2);
    check("rst_csn", uart_csn, 1);
    check("rst_wen", uart_wen, 1);
    check("rst_oen", uart_oen, 1);
    check("rst_data_in", uart_data_in, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_perr", rx_perr, 0);
    check("rst_rx_ferr", rx_ferr, 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_last_src", last_src, 0);
    RESET = 1'b0;

    // Single TX from requester 2
    push_req(2, 8'hA5);
    uart_txrdy = 1'b1;
    run(8);
    check("t1_writes", count_kind(0), 1);
    if (ev_idx.size() > 0) begin
      check("t1_idx", ev_idx[0], 2);
      check("t1_data", ev_dat[0], 8'hA5);
    end
    check("t1_last_src", last_src, 2);

    // Fairness with all requesters active
    reset_all();
    push_req(0, 8'h10); push_req(1, 8'h11); push_req(2, 8'h12); push_req(3, 8'h13);
    push_req(0, 8'h14);
    uart_txrdy = 1'b1;
    run(25);
    fair = '{0, 1, 2, 3, 0};
    check("t2_writes", count_kind(0), 5);
    for (int k = 0; k < 5 && k < ev_idx.size(); k++) begin
      check("t2_order", ev_idx[k], fair[k]);
      if (k > 0) check("t2_gap", ev_cyc[k] - ev_cyc[k-1] - 1, GUARD + 1);
    end

    // RX wins over a simultaneous TX
    reset_all();
    src_q.push_back({1'b1, 1'b0, 8'h3C});
    push_req(0, 8'h77);
    uart_txrdy = 1'b1;
    run(12);
    check("t3_events", ev_kind.size(), 2);
    if (ev_kind.size() >= 2) begin
      check("t3_first_read", ev_kind[0], 1);
      check("t3_then_write", ev_kind[1], 0);
      check("t3_wr_delay", ev_cyc[1] - ev_cyc[0], RD_LAT + GUARD + 2);
    end
    check("t3_rx_valid", rx_valid, 1);
    check("t3_rx_data", rx_data, 8'h3C);
    check("t3_rx_perr", rx_perr, 1);
    check("t3_rx_ferr", rx_ferr, 0);
    rx_ready = 1'b1;
    run(3);

    // RX backpressure
    reset_all();
    src_q.push_back({1'b0, 1'b0, 8'h5A});
    src_q.push_back({1'b0, 1'b1, 8'hC3});
    run(20);
    check("t4_reads_held", count_kind(1), RXCAP);
    check("t4_uart_left", src_q.size(), 2 - RXCAP);
    check("t4_rx_data", rx_data, 8'h5A);
    rx_ready = 1'b1;
    run(20);
    check("t4_reads_all", count_kind(1), 2);
    check("t4_drained", pending(), 0);

    // Overflow sticky
    reset_all();
    uart_overflow = 1'b1;
    run(1);
    uart_overflow = 1'b0;
    run(4);
    check("t5_ovf_set", ovf_sticky, 1);
    RESET = 1'b1;
    run(1);
    RESET = 1'b0;
    check("t5_ovf_clr", ovf_sticky, 0);

    // Reset during RD_STB
    reset_all();
    rx_ready = 1'b1;
    src_q.push_back({1'b0, 1'b0, 8'h99});
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      step();
      if (uart_oen === 1'b0) seen = 1;
    end
    check("t6_oen_seen", seen, 1);
    RESET = 1'b1;
    step();
    check("t6_strobes", {uart_csn, uart_wen, uart_oen}, 3'b111);
    check("t6_rx_valid", rx_valid, 0);
    RESET = 1'b0;
    ev_kind.delete(); ev_idx.delete(); ev_cyc.delete(); ev_dat.delete();
    push_req(1, 8'h42);
    uart_txrdy = 1'b1;
    run(1);
    check("t6_idle_write", count_kind(0), 1);
    run(6);

    // Randomized traffic
    reset_all();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ri = $urandom_range(0, NREQ - 1);
        if (rq_cnt[ri] < 8) push_req(ri, 8'($urandom));
      end
      if ($urandom_range(0, 9) == 0 && src_q.size() < 6) src_q.push_back(10'($urandom));
      uart_txrdy    = ($urandom_range(0, 9) < 7);
      rx_ready      = ($urandom_range(0, 3) != 0);
      uart_overflow = ($urandom_range(0, 199) == 0);
      step();
    end
    uart_txrdy = 1'b1;
    rx_ready = 1'b1;
    uart_overflow = 1'b0;
    budget = 0;
    while (pending() > 0 && budget < 2000) begin
      step();
      budget++;
    end
    check("rand_drained", pending(), 0);
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_host_ctrl.md
Name: uart_host_ctrl

Overview:
- Host-side sequencer for the CoreUART macro wrapper.
- Round-robin arbitrates NREQ byte-stream transmit requesters onto the single UART write port.
- Drives the active-low CSN/WEN/OEN strobes and harvests received bytes with their error flags into a valid/ready stream.
- RX service has priority over TX to minimise UART OVERFLOW.

Parameters:
- NREQ, 4, number of TX requesters (2..8).
- GUARD, 2, idle cycles after any strobe before TXRDY/RXRDY are re-sampled (1..7).
- RD_LAT, 1, cycles from OEN low to DATA_OUT valid (1..3).

Ports:
- CLK  in  1  single clock for all logic.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester i at bits [8i+7:8i].
- req_ready  out  NREQ  one-hot; high for the single cycle requester i's byte is accepted.
- rx_valid  out  1  received byte available.
- rx_data  out  8  received byte.
- rx_perr  out  1  PARITY_ERR captured with the byte.
- rx_ferr  out  1  FRAMING_ERR captured with the byte.
- rx_ready  in  1  consumer accepts rx byte.
- ovf_sticky  out  1  set on any UART OVERFLOW; cleared only by reset.
- last_src  out  3  index of the last granted requester.
- uart_csn, uart_wen, uart_oen  out  1 each  active-low UART strobes.
- uart_data_in  out  8  byte to UART.
- uart_data_out  in  8  byte from UART.
- uart_txrdy, uart_rxrdy, uart_parity_err, uart_framing_err, uart_overflow  in  1 each  UART status.

Behaviour:
- Reset values: uart_csn=1, uart_wen=1, uart_oen=1, uart_data_in=0, req_ready=0, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, ovf_sticky=0, last_src=0, FSM=IDLE, round-robin pointer=0.
- Reset asserted mid-operation aborts any strobe in the same edge. The UART byte is not retried.
- FSM states: IDLE, WR_STB, RD_STB, RD_WAIT, RD_CAP, GUARD_WAIT.
- IDLE:
  - If uart_rxrdy and the RX output slot is free -> RD_STB.
  - Else if uart_txrdy and any req_valid -> WR_STB.
  - Else stay in IDLE.
- Same-cycle RX and TX eligibility: RX wins.
- WR_STB (1 cycle):
  - uart_csn=0, uart_wen=0, uart_data_in = byte of the granted requester.
  - req_ready[grant]=1 this cycle; last_src<=grant.
  - RR pointer <= grant+1, wrapping NREQ-1 -> 0.
  - Next state GUARD_WAIT.
- RD_STB (1 cycle): uart_csn=0, uart_oen=0.
  - Next state RD_WAIT for RD_LAT-1 cycles (strobes inactive), then RD_CAP.
  - RD_LAT=1 goes directly RD_STB -> RD_CAP.
- RD_CAP:
  - Latch uart_data_out, uart_parity_err, uart_framing_err into the RX slot; set rx_valid.
  - Next state GUARD_WAIT.
- GUARD_WAIT: counts GUARD cycles with all strobes high, then IDLE. Minimum TX byte spacing = 1+GUARD cycles.
- Grant selection: first valid requester at or after the RR pointer. It is combinational in IDLE and registered into WR_STB. The grant is frozen once WR_STB is entered.
- The requester's byte must be held while req_valid is high.
- req_valid dropping before WR_STB: the request is simply not granted, provided the arbiter re-evaluates on the IDLE cycle.
- RX stream:
  - rx_valid && rx_ready completes the transfer and frees the slot that cycle.
  - Slot full: the controller does not issue RD_STB; the byte waits in the UART.
- ovf_sticky <= ovf_sticky | uart_overflow, every cycle, in every state.
- Strobes are registered outputs. No combinational path from any input to any uart_* output.

Optional Feature:
- Macro: UART_HOST_CTRL_RXBUF_EN.
- Defined: RX output is a 2-entry FIFO.
  - RD_STB is allowed whenever at least one entry is free.
  - Simultaneous push and pop on a full FIFO is legal.
  - rx_* present the oldest entry.
- Undefined: single-entry register slot as described in Behaviour.

Decomposition:
- Shared package uart_host_pkg:
  - state enum typedef.
  - BYTE_W=8.
  - Strobe active level constant STB_ACT=1'b0.
  - Max NREQ constant 8.
- One sub-module: uart_rr_arb, the NREQ-wide round-robin grant with pointer register, update enable and index output.

Test Plan:
- Single TX: req_valid[2]=1, data 0xA5, txrdy=1 -> one WEN-low cycle with uart_data_in=0xA5, req_ready[2] pulses once, last_src=2.
- Fairness: all four req_valid held, txrdy=1 -> grant order 0,1,2,3,0 with 1+GUARD=3 cycles between WEN pulses.
- RX priority: rxrdy and txrdy plus req_valid[0] in the same cycle -> OEN pulse first; RD_LAT later rx_data=0x3C (UART drives 0x3C), perr/ferr copied; WEN follows after GUARD.
- Backpressure: rx_ready=0, two bytes arrive -> without the macro only one OEN pulse is issued and the second byte stays in the UART; with the macro both bytes are read, then no OEN pulses until rx_ready is asserted.
- Overflow: uart_overflow pulses 1 cycle -> ovf_sticky=1 and held until RESET=1, then 0.
- Reset mid-read: RESET asserted in the RD_STB cycle -> next cycle all strobes=1, rx_valid=0, FSM in IDLE.
